// File: rtl/md_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg (package)
// Purpose  : Shared definitions for the multiply/divide scheduler: MD-class
//            operation encodings, default job latencies and the FSM state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  // E-stage MD operation encodings; 9..15 behave as MD_NONE
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/md_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : md_sched_if (interface)
// Purpose  : E/D-stage request bundle and HI/LO result bundle of the
//            multiply/divide scheduler.
// Ports    : master - pipeline side (drives E_md_op/E_a/E_b/D_is_md)
//            slave  - md_sched side (drives start/busy/md_stall/hi/lo/md_rdata)
// Revision : 1.0 - initial release
// ============================================================================
interface md_sched_if;
  logic [3:0]  E_md_op;
  logic [31:0] E_a;
  logic [31:0] E_b;
  logic        D_is_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output E_md_op, E_a, E_b, D_is_md,
    input  start, busy, md_stall, hi, lo, md_rdata
  );

  modport slave (
    input  E_md_op, E_a, E_b, D_is_md,
    output start, busy, md_stall, hi, lo, md_rdata
  );
endinterface
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Purpose  : Purely combinational multiply/divide datapath.
// Ports    : op          - MD operation code
//            a, b        - operands (rs, rt)
//            result      - {hi, lo}: 64-bit product, or {remainder, quotient}
//            div_by_zero - DIV/DIVU with b == 0
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic        [31:0] w_ub;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;
  logic               w_b_zero;

  assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_umul = {32'd0, a} * {32'd0, b};

  assign w_b_zero    = (b == 32'd0);
  assign div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && w_b_zero;

  // Divider never sees zero; the quotient is discarded by the scheduler then.
  assign w_ub    = w_b_zero ? 32'd1 : b;
  assign w_sa    = $signed(a);
  assign w_sb    = $signed(w_ub);
  assign w_squot = w_sa / w_sb;   // truncates toward zero
  assign w_srem  = w_sa % w_sb;   // takes the sign of the dividend
  assign w_uquot = a / w_ub;
  assign w_urem  = a % w_ub;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = w_smul;
      MD_MULTU: result = w_umul;
      MD_DIV:   result = {w_srem, w_squot};
      MD_DIVU:  result = {w_urem, w_uquot};
      default:  result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Purpose  : Multiply/divide scheduler. Accepts MD-class ops from E, runs
//            fixed-latency mult/div jobs, owns HI/LO and requests D-stage
//            stalls while a job is being accepted or is in flight.
// Ports    : clk   - clock
//            reset - synchronous, active-low reset
//            bus   - md_sched_if.slave (E op/operands, D_is_md, start, busy,
//                    md_stall, hi, lo, md_rdata)
// Revision : 1.0 - initial release
// ============================================================================
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_result;
  logic        w_div0;
  logic        w_is_div;
  logic        w_is_job;
  logic        w_start;
  logic        w_busy;

  md_arith u_arith (
    .op          (bus.E_md_op),
    .a           (bus.E_a),
    .b           (bus.E_b),
    .result      (w_result),
    .div_by_zero (w_div0)
  );

  assign w_is_div = (bus.E_md_op == MD_DIV) || (bus.E_md_op == MD_DIVU);
  assign w_is_job = (bus.E_md_op == MD_MULT) || (bus.E_md_op == MD_MULTU) || w_is_div;
  assign w_start  = (r_state == ST_IDLE) && w_is_job;
  assign w_busy   = (r_state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            // HI/LO cannot change while busy, so parking their current value
            // as the pending result makes a divide-by-zero commit a no-op.
            if (w_div0) begin
              r_pend_hi <= r_hi;
              r_pend_lo <= r_lo;
            end else begin
              r_pend_hi <= w_result[63:32];
              r_pend_lo <= w_result[31:0];
            end
            r_cnt   <= w_is_div ? c_div_cnt : c_mult_cnt;
            r_state <= ST_BUSY;
          end else if (bus.E_md_op == MD_MTHI) begin
            r_hi <= bus.E_a;
          end else if (bus.E_md_op == MD_MTLO) begin
            r_lo <= bus.E_a;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start    = w_start;
  assign bus.busy     = w_busy;
  assign bus.md_stall = bus.D_is_md && (w_start || w_busy);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.md_rdata = (bus.E_md_op == MD_MFHI) ? r_hi :
                        (bus.E_md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Purpose  : Self-checking bench for md_sched: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a job-level model (remaining-cycle count and
//            arithmetic derived from magnitudes and signs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;
  import md_pkg::*;

  logic clk;
  logic reset;
  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

  function automatic bit is_job(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] chi,
                                             input logic [31:0] clo);
    longint na, nb, ma, mb, q, r;
    logic [63:0] p;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    case (op)
      4'd1: begin q = na * nb; p = q; end
      4'd2: p = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 0) p = {chi, clo};
        else begin
          ma = (na < 0) ? -na : na;
          mb = (nb < 0) ? -nb : nb;
          q = ma / mb;
          r = ma % mb;
          if ((na < 0) != (nb < 0)) q = -q;
          if (na < 0) r = -r;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {chi, clo};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_left <= 0; m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (is_job(bus.E_md_op)) begin
      {m_phi, m_plo} <= ref_result(bus.E_md_op, bus.E_a, bus.E_b, m_hi, m_lo);
      m_left <= (bus.E_md_op >= 4'd3) ? 10 : 5;
    end else if (bus.E_md_op == 4'd5) begin
      m_hi <= bus.E_a;
    end else if (bus.E_md_op == 4'd6) begin
      m_lo <= bus.E_a;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : b_cmp
    logic e_busy, e_start, e_stall;
    logic [31:0] e_rdata;
    if (cmp_en) begin
      e_busy  = (m_left != 0);
      e_start = !e_busy && is_job(bus.E_md_op);
      e_stall = bus.D_is_md && (e_start || e_busy);
      e_rdata = (bus.E_md_op == 4'd7) ? m_hi : (bus.E_md_op == 4'd8) ? m_lo : 32'd0;
      chk("start", {31'd0, bus.start}, {31'd0, e_start});
      chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      chk("md_stall", {31'd0, bus.md_stall}, {31'd0, e_stall});
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("md_rdata", bus.md_rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  logic        s_stall;
  logic [31:0] s_rdata;

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic d);
    bus.E_md_op = op;
    bus.E_a     = a;
    bus.E_b     = b;
    bus.D_is_md = d;
    @(negedge clk);
    s_stall = bus.md_stall;
    s_rdata = bus.md_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) step(MD_NONE, 32'd0, 32'd0, d);
  endtask

  initial begin : b_watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d expected 0", n_err);
    $fatal(1, "timeout");
  end

  initial begin : b_main
    logic [7:0]  stall_bits;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b0;
    step(MD_NONE, 0, 0, 0);
    cmp_en = 1'b1;
    idle(2, 0);
    reset = 1'b1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    // signed multiply: -2 * 3
    step(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'd0, bus.busy}, 32'd1);
      idle(1, 0);
    end
    chk("mult_done", {31'd0, bus.busy}, 32'd0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

    // signed divide: -7 / 2
    step(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", {31'd0, bus.busy}, 32'd1);
      idle(1, 0);
    end
    chk("div_done", {31'd0, bus.busy}, 32'd0);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("model_div_hi", m_hi, 32'hFFFF_FFFF);

    // unsigned divide: 7 / 2
    step(MD_DIVU, 32'd7, 32'd2, 0);
    idle(10, 0);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    // divide by zero leaves HI/LO untouched
    step(MD_MTHI, 32'h11, 32'd0, 0);
    chk("mthi", bus.hi, 32'h11);
    step(MD_MTLO, 32'h22, 32'd0, 0);
    chk("mtlo", bus.lo, 32'h22);
    step(MD_DIV, 32'd5, 32'd0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("div0_busy", {31'd0, bus.busy}, 32'd1);
      idle(1, 0);
    end
    chk("div0_hi", bus.hi, 32'h11);
    chk("div0_lo", bus.lo, 32'h22);

    // stall window with D_is_md held high
    stall_bits = '0;
    step(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
    stall_bits[0] = s_stall;
    for (int i = 1; i < 8; i++) begin
      step(MD_NONE, 0, 0, 1);
      stall_bits[i] = s_stall;
    end
    chk("stall_window", {24'd0, stall_bits}, 32'h3F);
    chk("multu_hi", bus.hi, 32'd1);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // no stall when D stage is not MD
    stall_bits = '0;
    step(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    stall_bits[0] = s_stall;
    for (int i = 1; i < 8; i++) begin
      step(MD_NONE, 0, 0, 0);
      stall_bits[i] = s_stall;
    end
    chk("stall_none", {24'd0, stall_bits}, 32'h0);

    // ops issued while busy are ignored; MFLO reads the old LO
    step(MD_MULT, 32'd3, 32'd4, 0);
    step(MD_MTLO, 32'h5, 32'd0, 0);
    step(MD_MFLO, 32'd0, 32'd0, 0);
    chk("mflo_busy", s_rdata, 32'hFFFF_FFFE);
    idle(3, 0);
    chk("ign_lo", bus.lo, 32'd12);
    chk("ign_hi", bus.hi, 32'd0);

    // reset in the middle of a divide
    step(MD_DIV, 32'd100, 32'd7, 0);
    idle(2, 0);
    reset = 1'b0;
    idle(1, 0);
    reset = 1'b1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    step(MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0);
    idle(5, 0);
    chk("post_rst_lo", bus.lo, 32'd30);
    chk("post_rst_hi", bus.hi, 32'd0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      reset = ($urandom_range(0, 99) != 0);
      step(op, a, b, 1'($urandom_range(0, 1)));
    end
    reset = 1'b1;
    idle(12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
